// File: rtl/mod_digit_counter.sv
// mod_digit_counter
// One decimal-style digit that counts 0..MODULUS-1 with wrap or clamp at the
// bounds. It has a synchronous clear and a synchronous load with range checking,
// and a sticky error flag. carry/borrow are registered one-cycle pulses, so one
// digit's carry can drive the next digit's inc directly without a combinational
// chain between digits.
//
// Handshake: there is none. inc/dec/clr/load are level requests sampled on every
// rising clk edge, and every accepted request takes effect on that edge.
module mod_digit_counter #(
    parameter int MODULUS  = 6,
    parameter int WIDTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             borrow,
    output logic             at_max,
    output logic             at_zero,
    output logic             err
);

    // Parameter legality is checked at elaboration, so a bad configuration never builds.
    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $error("mod_digit_counter: MODULUS must be in 2..16");
    end
    if (WIDTH < 1 || WIDTH > 8) begin : g_bad_width
        $error("mod_digit_counter: WIDTH must be in 1..8");
    end
    if ((2 ** WIDTH) < MODULUS) begin : g_too_narrow
        $error("mod_digit_counter: WIDTH too small to hold MODULUS-1");
    end

    // All comparisons and arithmetic use one extra bit. This lets q+1 at the top
    // of the range and an oversize load_val be compared without overflow.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_Q   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   q_plus;
    logic [WIDTH:0]   q_minus;

    logic [WIDTH-1:0] q_next;
    logic             carry_next;
    logic             borrow_next;
    logic             err_next;

    assign q_ext    = {1'b0, q};
    assign load_ext = {1'b0, load_val};
    assign q_plus   = q_ext + (WIDTH + 1)'(1);
    assign q_minus  = q_ext - (WIDTH + 1)'(1);

    // Next-state selection, priority clr > load > (inc xor dec) > hold.
    always_comb begin
        q_next      = q;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        err_next    = err;
        if (clr) begin
            q_next   = '0;
            err_next = 1'b0;
        end else if (load) begin
            if (load_ext > MAX_EXT) begin
                // An out-of-range load clamps to the top value and is flagged.
                q_next   = MAX_Q;
                err_next = 1'b1;
            end else begin
                q_next = load_val;
            end
        end else if (inc && !dec) begin
            if (q_ext == MAX_EXT) begin
                if (SATURATE == 0) begin
                    q_next     = '0;
                    carry_next = 1'b1;
                end
            end else begin
                q_next = q_plus[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (q_ext == '0) begin
                if (SATURATE == 0) begin
                    q_next      = MAX_Q;
                    borrow_next = 1'b1;
                end
            end else begin
                q_next = q_minus[WIDTH-1:0];
            end
        end
    end

    // State register. Reset is asynchronous and also cancels any pulse in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            err    <= 1'b0;
        end else begin
            q      <= q_next;
            carry  <= carry_next;
            borrow <= borrow_next;
            err    <= err_next;
        end
    end

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == '0);

endmodule

// File: tb/tb_mod_digit_counter.sv
// Directed bench for mod_digit_counter. It runs a wrapping MODULUS=6 instance
// and a saturating MODULUS=10 instance. The two share clk and rst_n.
module tb_mod_digit_counter;

    logic       clk;
    logic       rst_n;

    // MODULUS=6, wrapping
    logic       inc_a, dec_a, clr_a, load_a;
    logic [3:0] lv_a, q_a;
    logic       carry_a, borrow_a, at_max_a, at_zero_a, err_a;

    // MODULUS=10, saturating
    logic       inc_b, dec_b, clr_b, load_b;
    logic [3:0] lv_b, q_b;
    logic       carry_b, borrow_b, at_max_b, at_zero_b, err_b;

    int checks = 0;
    int errors = 0;

    mod_digit_counter #(.MODULUS(6), .WIDTH(4), .SATURATE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .inc(inc_a), .dec(dec_a), .clr(clr_a),
        .load(load_a), .load_val(lv_a), .q(q_a), .carry(carry_a),
        .borrow(borrow_a), .at_max(at_max_a), .at_zero(at_zero_a), .err(err_a)
    );

    mod_digit_counter #(.MODULUS(10), .WIDTH(4), .SATURATE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .inc(inc_b), .dec(dec_b), .clr(clr_b),
        .load(load_b), .load_val(lv_b), .q(q_b), .carry(carry_b),
        .borrow(borrow_b), .at_max(at_max_b), .at_zero(at_zero_b), .err(err_b)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        inc_a = 0; dec_a = 0; clr_a = 0; load_a = 0; lv_a = 0;
    endtask

    task automatic idle_b();
        inc_b = 0; dec_b = 0; clr_b = 0; load_b = 0; lv_b = 0;
    endtask

    logic [3:0] inc_q_exp [7];
    logic       inc_c_exp [7];

    initial begin
        inc_q_exp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        inc_c_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        idle_a();
        idle_b();
        rst_n = 1'b0;

        // Reset state
        #12;
        chk("rst_q",       8'(q_a), 8'd0);
        chk("rst_carry",   8'(carry_a), 8'd0);
        chk("rst_borrow",  8'(borrow_a), 8'd0);
        chk("rst_err",     8'(err_a), 8'd0);
        chk("rst_at_zero", 8'(at_zero_a), 8'd1);
        chk("rst_at_max",  8'(at_max_a), 8'd0);
        chk("rst_q_b",     8'(q_b), 8'd0);
        rst_n = 1'b1;

        // Seven increments through the wrap
        inc_a = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("inc7_q[%0d]", i), 8'(q_a), 8'(inc_q_exp[i]));
            chk($sformatf("inc7_carry[%0d]", i), 8'(carry_a), 8'(inc_c_exp[i]));
            chk($sformatf("inc7_borrow[%0d]", i), 8'(borrow_a), 8'd0);
        end
        inc_a = 0;

        // Clear, then down-wrap from zero
        clr_a = 1; step(); clr_a = 0;
        chk("clr_q", 8'(q_a), 8'd0);
        dec_a = 1; step();
        chk("dwrap_q", 8'(q_a), 8'd5);
        chk("dwrap_borrow", 8'(borrow_a), 8'd1);
        chk("dwrap_carry", 8'(carry_a), 8'd0);
        chk("dwrap_at_max", 8'(at_max_a), 8'd1);
        step();
        chk("dec2_q", 8'(q_a), 8'd4);
        chk("dec2_borrow", 8'(borrow_a), 8'd0);
        dec_a = 0; step();
        chk("hold_q", 8'(q_a), 8'd4);

        // Same-cycle combinations
        load_a = 1; lv_a = 4'd3; step(); load_a = 0;
        chk("load3_q", 8'(q_a), 8'd3);
        inc_a = 1; dec_a = 1; step();
        chk("incdec_q", 8'(q_a), 8'd3);
        chk("incdec_carry", 8'(carry_a), 8'd0);
        chk("incdec_borrow", 8'(borrow_a), 8'd0);
        dec_a = 0; clr_a = 1; load_a = 1; lv_a = 4'd2; step(); clr_a = 0;
        chk("clrloadinc_q", 8'(q_a), 8'd0);
        lv_a = 4'd4; step();
        chk("loadinc_q", 8'(q_a), 8'd4);
        chk("loadinc_carry", 8'(carry_a), 8'd0);
        load_a = 1; lv_a = 4'd5; inc_a = 1; step();
        chk("load5inc_q", 8'(q_a), 8'd5);
        chk("load5inc_carry", 8'(carry_a), 8'd0);
        idle_a();

        // Out-of-range load on the wrapping digit, then an up-wrap and async reset
        load_a = 1; lv_a = 4'd7; step(); load_a = 0;
        chk("oor_a_q", 8'(q_a), 8'd5);
        chk("oor_a_err", 8'(err_a), 8'd1);
        inc_a = 1; step(); inc_a = 0;
        chk("wrap_q", 8'(q_a), 8'd0);
        chk("wrap_carry", 8'(carry_a), 8'd1);
        chk("wrap_err_sticky", 8'(err_a), 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", 8'(q_a), 8'd0);
        chk("arst_carry", 8'(carry_a), 8'd0);
        chk("arst_err", 8'(err_a), 8'd0);
        #2 rst_n = 1'b1;
        inc_a = 1; step(); inc_a = 0;
        chk("post_rst_q", 8'(q_a), 8'd1);
        chk("post_rst_carry", 8'(carry_a), 8'd0);

        // Saturating MODULUS=10 digit
        load_b = 1; lv_b = 4'd9; step(); load_b = 0;
        chk("sat_load9_q", 8'(q_b), 8'd9);
        chk("sat_at_max", 8'(at_max_b), 8'd1);
        inc_b = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sat_inc_q[%0d]", i), 8'(q_b), 8'd9);
            chk($sformatf("sat_inc_carry[%0d]", i), 8'(carry_b), 8'd0);
        end
        chk("sat_inc_err", 8'(err_b), 8'd0);
        inc_b = 0;
        clr_b = 1; step(); clr_b = 0;
        chk("sat_clr_q", 8'(q_b), 8'd0);
        dec_b = 1; step(); dec_b = 0;
        chk("sat_dec0_q", 8'(q_b), 8'd0);
        chk("sat_dec0_borrow", 8'(borrow_b), 8'd0);
        chk("sat_dec0_err", 8'(err_b), 8'd0);
        load_b = 1; lv_b = 4'd12; step();
        chk("oor_b_q", 8'(q_b), 8'd9);
        chk("oor_b_err", 8'(err_b), 8'd1);
        lv_b = 4'd3; step(); load_b = 0;
        chk("inrange_load_q", 8'(q_b), 8'd3);
        chk("inrange_load_err", 8'(err_b), 8'd1);
        clr_b = 1; step(); clr_b = 0;
        chk("clr_err_q", 8'(q_b), 8'd0);
        chk("clr_err_err", 8'(err_b), 8'd0);
        inc_b = 1; step(); inc_b = 0;
        chk("sat_inc_from0", 8'(q_b), 8'd1);
        dec_b = 1; step(); dec_b = 0;
        chk("sat_dec_to0", 8'(q_b), 8'd0);
        chk("sat_at_zero", 8'(at_zero_b), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_digit_counter.md
MOD_DIGIT_COUNTER -- requirements
Module: mod_digit_counter

Interface
REQ-001 Parameter MODULUS, default 6: count range is 0..MODULUS-1, legal values 2..16.
REQ-002 Parameter WIDTH, default 4: width of the count and load value, legal values 1..8; elaboration SHALL fail if 2**WIDTH < MODULUS.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the bounds, 1 = clamp at the bounds.
REQ-004 clk  in  1  the single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 inc  in  1  count-up request, sampled at the rising edge of clk.
REQ-007 dec  in  1  count-down request, sampled at the rising edge of clk.
REQ-008 clr  in  1  synchronous clear to 0.
REQ-009 load  in  1  synchronous load of load_val.
REQ-010 load_val  in  WIDTH  value to load.
REQ-011 q  out  WIDTH  registered count.
REQ-012 carry  out  1  registered one-cycle pulse on an up-wrap.
REQ-013 borrow  out  1  registered one-cycle pulse on a down-wrap.
REQ-014 at_max  out  1  combinational, high when q == MODULUS-1.
REQ-015 at_zero  out  1  combinational, high when q == 0.
REQ-016 err  out  1  sticky flag, set when an out-of-range load is attempted.

Function
REQ-017 Priority per cycle SHALL be clr > load > (inc XOR dec) > hold.
REQ-018 clr SHALL set q to 0 and clear err; carry and borrow SHALL be 0 that cycle.
REQ-019 load with load_val <= MODULUS-1 SHALL set q to load_val and leave err unchanged.
REQ-020 load with load_val >= MODULUS SHALL set q to MODULUS-1 and set err.
REQ-021 load SHALL never assert carry or borrow.
REQ-022 inc=1 and dec=1 in the same cycle SHALL leave q unchanged, with no pulses.
REQ-023 Up-count (inc only), q < MODULUS-1: q SHALL become q+1.
REQ-024 Up-count at q == MODULUS-1, SATURATE=0: q SHALL become 0 and carry SHALL be 1 in the next cycle.
REQ-025 Down-count (dec only), q > 0: q SHALL become q-1.
REQ-026 Down-count at q == 0, SATURATE=0: q SHALL become MODULUS-1 and borrow SHALL be 1 in the next cycle.
REQ-027 SATURATE=1 at a bound: q SHALL hold and carry/borrow SHALL stay 0.
REQ-028 SATURATE=1 at a bound: the request SHALL be ignored without error.
REQ-029 carry and borrow SHALL be high for exactly one cycle per wrap and SHALL never both be 1.
REQ-030 Latency is one clock from the sampled request to the updated q, carry or borrow.
REQ-031 q SHALL never hold a value >= MODULUS.
REQ-032 Arithmetic SHALL be done in WIDTH+1 bits so that no intermediate value overflows.
REQ-033 Continuous inc for N cycles SHALL advance q by N mod MODULUS and produce floor((q0+N)/MODULUS) carry pulses.
REQ-034 carry of one instance SHALL be usable directly as inc of the next-higher digit; borrow likewise as dec.
REQ-035 No combinational path SHALL exist from inc, dec, clr or load to carry or borrow.

Reset
REQ-036 rst_n low SHALL force q=0, carry=0, borrow=0 and err=0 immediately, independent of clk.
REQ-037 Assertion of rst_n mid-operation, including during a carry or borrow pulse, SHALL abort that pulse within the same cycle.
REQ-038 Following rst_n deassertion, the first rising edge of clk SHALL process inputs normally.
REQ-039 After reset, at_zero=1 and at_max=0.

Verification
REQ-040 MODULUS=6: reset, then 7 inc pulses -> q reads 1..5,0,1; carry is 1 only in the cycle after 5->0.
REQ-041 MODULUS=6: from q=0, one dec -> q=5 and borrow=1 for one cycle; a further dec -> q=4 with borrow=0.
REQ-042 MODULUS=10, SATURATE=1: load 9, then inc x3 -> q stays 9 and carry stays 0; dec from 0 -> q stays 0.
REQ-043 load_val=12 with MODULUS=10 -> q=9 and err=1; a subsequent clr -> q=0 and err=0.
REQ-044 Same-cycle events: inc+dec at q=3 -> q=3; clr+load+inc -> q=0; load=4 together with inc -> q=4.
REQ-045 rst_n pulled low asynchronously while carry=1 -> q, carry and err are 0 before the next rising edge of clk.
